// File: rtl/mult_defs_pkg.sv
// Shared state encoding and iteration constants for the shift-add multiplier.
package mult_defs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [2:0] ITER_LAST = 3'd3;

endpackage

// File: rtl/four_bit_full_adder.sv
// 4-bit ripple-carry adder built from per-bit full-adder equations.
module four_bit_full_adder (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] sum,
    output logic       cout
);

    logic [4:0] carry;

    always_comb begin
        carry    = '0;
        sum      = '0;
        carry[0] = cin;
        for (int i = 0; i < 4; i++) begin
            sum[i]       = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout = carry[4];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned 4x4 multiplier: four shift-add iterations through one shared 4-bit adder.
module shift_add_multiplier
    import mult_defs_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic       busy,
    output logic       done,
    output logic [7:0] product
);

    state_t     state;
    logic [3:0] mcand;
    logic [8:0] p;
    logic [2:0] cnt;

    logic [3:0] add_b;
    logic [3:0] add_sum;
    logic       add_cout;
    logic [8:0] p_sum;

    assign add_b = p[0] ? mcand : 4'b0;

    four_bit_full_adder u_adder (
        .a    (p[7:4]),
        .b    (add_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // Carry lands in bit 8 before the shift so nothing is lost.
    assign p_sum = {add_cout, add_sum, p[3:0]};

    assign busy = (state == ST_RUN) || (state == ST_DONE);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            mcand   <= 4'b0;
            p       <= 9'b0;
            cnt     <= 3'b0;
            product <= 8'h00;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        mcand <= a;
                        p     <= {1'b0, 4'b0, b};
                        cnt   <= 3'b0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    p   <= {1'b0, p_sum[8:1]};
                    cnt <= cnt + 3'd1;
                    if (cnt == ITER_LAST) begin
                        product <= p_sum[8:1];
                        state   <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and exhaustive bench for shift_add_multiplier with an expected-product queue.
module tb_shift_add_multiplier;

    logic       clk;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic       busy;
    logic       done;
    logic [7:0] product;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    shift_add_multiplier dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pop_compare(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            check({tag, "_queue_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check(tag, {24'b0, product}, {24'b0, e});
        end
    endtask

    // Waits for done with a bound; returns edges taken since the call.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic run_op(input logic [3:0] x, input logic [3:0] y);
        int lat;
        start = 1'b1;
        a     = x;
        b     = y;
        exp_q.push_back({4'b0, x} * {4'b0, y});
        tick();
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 20) begin
            check("busy_run", {31'b0, busy}, 32'd1);
            if (lat == 1) begin
                start = 1'b1;
                a     = 4'd7;
                b     = 4'($urandom_range(0, 15));
            end
            if (lat == 2) start = 1'b0;
            tick();
            lat++;
        end
        check("latency", lat, 32'd4);
        check("busy_done", {31'b0, busy}, 32'd1);
        pop_compare("product");
        tick();
        check("done_pulse", {31'b0, done}, 32'd0);
        check("busy_idle", {31'b0, busy}, 32'd0);
    endtask

    initial begin
        int lat;
        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        tick();
        tick();
        rst = 1'b0;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        check("reset_product", {24'b0, product}, 32'd0);

        run_op(4'd15, 4'd15);
        run_op(4'd9, 4'd6);
        run_op(4'd0, 4'd13);
        run_op(4'd13, 4'd0);

        // start held high: one result every 6 edges
        start = 1'b1;
        a     = 4'd3;
        b     = 4'd5;
        exp_q.push_back(8'd15);
        tick();
        wait_done(lat);
        check("cont_latency", lat, 32'd4);
        pop_compare("cont_product");
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(8'd15);
            tick();
            wait_done(lat);
            check("cont_period", lat + 1, 32'd6);
            pop_compare("cont_product");
        end
        start = 1'b0;
        tick();
        check("cont_idle", {31'b0, busy}, 32'd0);

        // reset during iteration 2 aborts the operation
        start = 1'b1;
        a     = 4'd11;
        b     = 4'd9;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("midrun_busy", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_product", {24'b0, product}, 32'd0);
        run_op(4'd2, 4'd7);

        // rst wins over start in the same cycle
        rst   = 1'b1;
        start = 1'b1;
        a     = 4'd5;
        b     = 4'd5;
        tick();
        rst   = 1'b0;
        start = 1'b0;
        check("rst_start_busy", {31'b0, busy}, 32'd0);
        tick();
        check("rst_start_busy2", {31'b0, busy}, 32'd0);
        check("rst_start_done", {31'b0, done}, 32'd0);
        check("rst_start_product", {24'b0, product}, 32'd0);

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(4'(x), 4'(y));
            end
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
